// File: rtl/automation_pkg.sv
// Shared types and defaults for the home-automation controller: mode encoding,
// default climate thresholds and the counter-width helper.
package automation_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFire    = 3'd1,
    StDoor    = 3'd2,
    StWin     = 3'd3,
    StClimate = 3'd4
  } state_e;

  localparam int unsigned TLowDefault  = 18;
  localparam int unsigned THighDefault = 26;
  localparam int unsigned HystDefault  = 1;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/door_hold_timer.sv
// One door channel: keeps the actuator open for HOLD_CYC cycles after the
// presence sensor (or the fire override) was last seen.
module door_hold_timer #(
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned CntW     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic sdoor,
  input  logic fire_force,
  output logic door_next,
  output logic door_out
);

  localparam logic [CntW-1:0] HoldVal = CntW'(HOLD_CYC);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (sdoor || fire_force) begin
      cnt_d = HoldVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
    door_next = sdoor | fire_force | (cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      door_out <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      door_out <= door_next;
    end
  end

endmodule

// File: rtl/automation_sys_gen.sv
// Home-automation controller top: mode FSM, window debounce, climate hysteresis.
// Optional macro AUTOSYS_WIN_INTERLOCK_EN: open window forces heater/cooler off.
module automation_sys_gen
  import automation_pkg::*;
#(
  parameter int unsigned N_DOOR   = 2,
  parameter int unsigned N_WIN    = 1,
  parameter int unsigned TEMP_W   = 8,
  parameter int unsigned T_LOW    = TLowDefault,
  parameter int unsigned T_HIGH   = THighDefault,
  parameter int unsigned HYST     = HystDefault,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned DEB_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_DOOR-1:0] sdoor,
  input  logic [N_WIN-1:0]  swin,
  input  logic              sfire,
  input  logic              fire_ack,
  input  logic [TEMP_W-1:0] temp,
  output logic [N_DOOR-1:0] door_out,
  output logic              winbuzz,
  output logic              alarmbuzz,
  output logic              heater,
  output logic              cooler,
  output logic [2:0]        state
);

  localparam int unsigned DoorW = cnt_width(HOLD_CYC);
  localparam int unsigned WinW  = cnt_width(DEB_CYC);

  localparam logic [TEMP_W-1:0] HeatOn  = TEMP_W'(T_LOW);
  localparam logic [TEMP_W-1:0] HeatOff = TEMP_W'(T_LOW + HYST);
  localparam logic [TEMP_W-1:0] CoolOn  = TEMP_W'(T_HIGH);
  localparam logic [TEMP_W-1:0] CoolOff = TEMP_W'(T_HIGH - HYST);
  localparam logic [WinW-1:0]   DebMax  = WinW'(DEB_CYC);

  state_e            state_q, state_d;
  logic [WinW-1:0]   win_cnt_q, win_cnt_d;
  logic              win_deb_q, win_deb_d;
  logic              heat_q, heat_d;
  logic              cool_q, cool_d;
  logic              winbuzz_q, winbuzz_d;
  logic              alarm_q, alarm_d;
  logic              heater_q, heater_d;
  logic              cooler_q, cooler_d;
  logic              fire_d;
  logic [N_DOOR-1:0] door_d;

  for (genvar i = 0; i < N_DOOR; i++) begin : g_door
    door_hold_timer #(
      .HOLD_CYC(HOLD_CYC),
      .CntW    (DoorW)
    ) u_door (
      .clk       (clk),
      .rst       (rst),
      .sdoor     (sdoor[i]),
      .fire_force(fire_d),
      .door_next (door_d[i]),
      .door_out  (door_out[i])
    );
  end

  // Fire is sticky: only a clear sensor together with an ack releases it.
  assign fire_d = sfire | ((state_q == StFire) & ~fire_ack);

  always_comb begin
    win_cnt_d = '0;
    win_deb_d = 1'b0;
    if (|swin) begin
      win_cnt_d = (win_cnt_q == DebMax) ? win_cnt_q : win_cnt_q + WinW'(1);
      win_deb_d = (win_cnt_d == DebMax);
    end
  end

  always_comb begin
    heat_d = heat_q;
    cool_d = cool_q;
    if (temp < HeatOn) begin
      heat_d = 1'b1;
      cool_d = 1'b0;
    end else if (temp > HeatOff) begin
      heat_d = 1'b0;
    end
    if (temp > CoolOn) begin
      cool_d = 1'b1;
      heat_d = 1'b0;
    end else if (temp < CoolOff) begin
      cool_d = 1'b0;
    end
`ifdef AUTOSYS_WIN_INTERLOCK_EN
    if (win_deb_d) begin
      heat_d = 1'b0;
      cool_d = 1'b0;
    end
`endif
  end

  // Latches keep running during FIRE; only the driven outputs are masked.
  always_comb begin
    alarm_d   = fire_d;
    winbuzz_d = win_deb_d & ~fire_d;
    heater_d  = heat_d & ~fire_d;
    cooler_d  = cool_d & ~fire_d;
    state_d   = StIdle;
    if (fire_d) begin
      state_d = StFire;
    end else if (|door_d) begin
      state_d = StDoor;
    end else if (win_deb_d) begin
      state_d = StWin;
    end else if (heat_d || cool_d) begin
      state_d = StClimate;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      win_cnt_q <= '0;
      win_deb_q <= 1'b0;
      heat_q    <= 1'b0;
      cool_q    <= 1'b0;
      winbuzz_q <= 1'b0;
      alarm_q   <= 1'b0;
      heater_q  <= 1'b0;
      cooler_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      win_deb_q <= win_deb_d;
      heat_q    <= heat_d;
      cool_q    <= cool_d;
      winbuzz_q <= winbuzz_d;
      alarm_q   <= alarm_d;
      heater_q  <= heater_d;
      cooler_q  <= cooler_d;
    end
  end

  assign state     = state_q;
  assign winbuzz   = winbuzz_q;
  assign alarmbuzz = alarm_q;
  assign heater    = heater_q;
  assign cooler    = cooler_q;

  // win_deb_q mirrors the debounced window for readability in waveforms.
  logic unused_deb;
  assign unused_deb = win_deb_q;

endmodule

// File: tb/tb_automation_sys_gen.sv
// Directed self-checking bench for automation_sys_gen with default parameters.
module tb_automation_sys_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sdoor;
  logic [0:0] swin;
  logic       sfire;
  logic       fire_ack;
  logic [7:0] temp;
  logic [1:0] door_out;
  logic       winbuzz;
  logic       alarmbuzz;
  logic       heater;
  logic       cooler;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  automation_sys_gen dut (
    .clk      (clk),
    .rst      (rst),
    .sdoor    (sdoor),
    .swin     (swin),
    .sfire    (sfire),
    .fire_ack (fire_ack),
    .temp     (temp),
    .door_out (door_out),
    .winbuzz  (winbuzz),
    .alarmbuzz(alarmbuzz),
    .heater   (heater),
    .cooler   (cooler),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sdoor = '0; swin = '0; sfire = 0; fire_ack = 0; temp = 8'd22;
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  task automatic test_reset();
    sdoor = 2'b11; swin = 1'b1; sfire = 1; fire_ack = 1; temp = 8'd22;
    rst = 0;
    step();
    step();
    checks++;
    if ({door_out, winbuzz, alarmbuzz, heater, cooler} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {door_out, winbuzz, alarmbuzz, heater, cooler});
    end
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    rst = 1;
    step();
    checks++;
    if (state !== 3'd1 || alarmbuzz !== 1'b1 || door_out !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_fire: state %0d alarm %b door %b expected 1 1 11",
               state, alarmbuzz, door_out);
    end
  endtask

  task automatic test_door_hold();
    do_reset();
    sdoor = 2'b01;
    step();
    sdoor = 2'b00;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) step();
      checks++;
      if (door_out !== 2'b01 || state !== 3'd2) begin
        errors++;
        $display("FAIL door_hold cycle %0d: door %b state %0d expected 01 2", i, door_out, state);
      end
    end
    step();
    checks++;
    if (door_out !== 2'b00 || state !== 3'd0) begin
      errors++;
      $display("FAIL door_release: door %b state %0d expected 00 0", door_out, state);
    end
  endtask

  task automatic test_window();
    do_reset();
    swin = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (winbuzz !== 1'b0) begin
        errors++; $display("FAIL win_short edge %0d: got %b expected 0", k, winbuzz);
      end
    end
    swin = 1'b0;
    step();
    swin = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (winbuzz !== (k >= 4) || state !== ((k >= 4) ? 3'd3 : 3'd0)) begin
        errors++;
        $display("FAIL win_debounce edge %0d: buzz %b state %0d expected %b %0d",
                 k, winbuzz, state, (k >= 4), (k >= 4) ? 3 : 0);
      end
    end
    swin = 1'b0;
    step();
    checks++;
    if (winbuzz !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL win_clear: buzz %b state %0d expected 0 0", winbuzz, state);
    end
  endtask

  task automatic test_climate();
    logic [7:0] temps [8] = '{8'd20, 8'd17, 8'd18, 8'd19, 8'd20, 8'd27, 8'd25, 8'd24};
    logic       exp_h [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       exp_c [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      temp = temps[i];
      step();
      checks++;
      if (heater !== exp_h[i] || cooler !== exp_c[i] ||
          state !== ((exp_h[i] | exp_c[i]) ? 3'd4 : 3'd0)) begin
        errors++;
        $display("FAIL climate temp=%0d: heat %b cool %b state %0d expected %b %b",
                 temps[i], heater, cooler, state, exp_h[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_fire();
    do_reset();
    temp = 8'd10;
    sfire = 1;
    for (int i = 0; i < 3; i++) begin
      fire_ack = (i > 0);
      step();
      checks++;
      if (state !== 3'd1 || alarmbuzz !== 1'b1 || door_out !== 2'b11 || heater !== 1'b0) begin
        errors++;
        $display("FAIL fire_active %0d: state %0d alarm %b door %b heat %b expected 1 1 11 0",
                 i, state, alarmbuzz, door_out, heater);
      end
    end
    sfire = 0; fire_ack = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (state !== 3'd1 || alarmbuzz !== 1'b1) begin
        errors++;
        $display("FAIL fire_sticky %0d: state %0d alarm %b expected 1 1", i, state, alarmbuzz);
      end
    end
    fire_ack = 1;
    step();
    fire_ack = 0;
    checks++;
    if (alarmbuzz !== 1'b0 || state !== 3'd2 || door_out !== 2'b11 || heater !== 1'b1) begin
      errors++;
      $display("FAIL fire_exit: alarm %b state %0d door %b heat %b expected 0 2 11 1",
               alarmbuzz, state, door_out, heater);
    end
    temp = 8'd22;
    for (int i = 1; i < 16; i++) begin
      step();
      checks++;
      if (door_out !== 2'b11) begin
        errors++; $display("FAIL fire_door_hold %0d: got %b expected 11", i, door_out);
      end
    end
    step();
    checks++;
    if (door_out !== 2'b00 || state !== 3'd0) begin
      errors++;
      $display("FAIL fire_door_release: door %b state %0d expected 00 0", door_out, state);
    end
  endtask

  task automatic test_interlock();
    logic exp_heat;
`ifdef AUTOSYS_WIN_INTERLOCK_EN
    exp_heat = 1'b0;
`else
    exp_heat = 1'b1;
`endif
    do_reset();
    temp = 8'd10;
    step();
    checks++;
    if (heater !== 1'b1 || state !== 3'd4) begin
      errors++; $display("FAIL interlock_pre: heat %b state %0d expected 1 4", heater, state);
    end
    swin = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    checks++;
    if (winbuzz !== 1'b1 || heater !== exp_heat || state !== 3'd3) begin
      errors++;
      $display("FAIL interlock_win: buzz %b heat %b state %0d expected 1 %b 3",
               winbuzz, heater, state, exp_heat);
    end
    swin = 1'b0;
    step();
    checks++;
    if (winbuzz !== 1'b0 || heater !== 1'b1 || state !== 3'd4) begin
      errors++;
      $display("FAIL interlock_rearm: buzz %b heat %b state %0d expected 0 1 4",
               winbuzz, heater, state);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sdoor = 2'b10; swin = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (state !== 3'd2 || door_out !== 2'b10 || winbuzz !== (k >= 4)) begin
        errors++;
        $display("FAIL door_win edge %0d: state %0d door %b buzz %b expected 2 10 %b",
                 k, state, door_out, winbuzz, (k >= 4));
      end
    end
    sdoor = 2'b00; swin = 1'b0;
    step();
    checks++;
    if (state !== 3'd2 || door_out !== 2'b10 || winbuzz !== 1'b0) begin
      errors++;
      $display("FAIL door_win_release: state %0d door %b buzz %b expected 2 10 0",
               state, door_out, winbuzz);
    end
  endtask

  initial begin
    test_reset();
    test_door_hold();
    test_window();
    test_climate();
    test_fire();
    test_interlock();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
